// File: rtl/mxn_pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mxn_pipe_pkg
//  Description : Shared constants, transfer-status type and select-clamp
//                helper for the mxn_pipe registered N:1 channel selector.
//  Contents    : MXN_MAX_N / MXN_MAX_W  - legal upper bounds for N and W
//                mxn_xfer_t             - per-cycle input/output handshake
//                mxn_eff_sel()          - maps out-of-range select to N-1
//  Revision    : 1.0  initial release
// ============================================================================
package mxn_pipe_pkg;

    localparam int MXN_MAX_N = 32;
    localparam int MXN_MAX_W = 64;

    // Handshake outcome for the current cycle.
    typedef struct packed {
        logic in_fire;   // selected channel word accepted at this edge
        logic out_fire;  // stored word consumed downstream at this edge
    } mxn_xfer_t;

    // A latched select beyond the last channel behaves as the last channel,
    // so a stale or oversized select can never address a missing source.
    function automatic int unsigned mxn_eff_sel(input int unsigned sel,
                                                input int unsigned n);
        return (sel >= n) ? (n - 1) : sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mxn_pipe_slot.sv
`default_nettype none
// ============================================================================
//  Module      : mxn_slot
//  Description : One W-bit storage slot with a valid flag. Load has priority
//                over clear so a simultaneous drain-and-refill keeps the slot
//                occupied with the new word.
//  Ports       : sys_clk_i  - clock, rising edge
//                resetl_i   - synchronous active-low reset (empties slot)
//                ld_i       - capture d_i, mark valid
//                clr_i      - mark empty (ignored when ld_i=1)
//                d_i        - word to capture
//                q_o        - stored word
//                vld_o      - slot holds a word
//  Revision    : 1.0  initial release
// ============================================================================
module mxn_slot #(
    parameter int W = 1
) (
    input  logic         sys_clk_i,
    input  logic         resetl_i,
    input  logic         ld_i,
    input  logic         clr_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o,
    output logic         vld_o
);

    logic [W-1:0] data_q;
    logic [W-1:0] data_d;
    logic         vld_q;
    logic         vld_d;

    always_comb begin
        data_d = data_q;
        vld_d  = vld_q;
        if (ld_i) begin
            data_d = d_i;
            vld_d  = 1'b1;
        end else if (clr_i) begin
            vld_d  = 1'b0;
        end
    end

    always_ff @(posedge sys_clk_i) begin
        if (!resetl_i) begin
            data_q <= '0;
            vld_q  <= 1'b0;
        end else begin
            data_q <= data_d;
            vld_q  <= vld_d;
        end
    end

    assign q_o   = data_q;
    assign vld_o = vld_q;

endmodule
`default_nettype wire

// File: rtl/mxn_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : mxn_pipe
//  Description : Parametrised registered N:1 channel selector with latched
//                select, valid/ready flow control and an active-high gate
//                (gn) that blanks the output and stalls draining.
//  Parameters  : N  - channel count (2..32)
//                W  - data width per channel (1..64)
//                SW - select width, derived from N; do not override
//  Ports       : sys_clk   in  1     clock, rising edge
//                resetl    in  1     synchronous active-low reset
//                in_data   in  N*W   channel i at [i*W +: W]
//                in_valid  in  N     per-channel valid
//                in_ready  out N     per-channel accept, at most one set
//                sel       in  SW    next channel select
//                sel_ld    in  1     load sel into the latched select
//                sel_q     out SW    latched select in effect
//                gn        in  1     gate: blank output, hold storage
//                out_data  out W     selected word, registered
//                out_valid out 1     out_data holds a word
//                out_ready in  1     downstream accept
//  Build macro : MXN_PIPE_SKID_EN - adds a skid slot so in_ready is a pure
//                register output; undefined gives the single-slot datapath.
//  Revision    : 1.0  initial release
// ============================================================================
module mxn_pipe
    import mxn_pipe_pkg::*;
#(
    parameter int N  = 8,
    parameter int W  = 1,
    parameter int SW = $clog2(N)
) (
    input  logic           sys_clk,
    input  logic           resetl,
    input  logic [N*W-1:0] in_data,
    input  logic [N-1:0]   in_valid,
    output logic [N-1:0]   in_ready,
    input  logic [SW-1:0]  sel,
    input  logic           sel_ld,
    output logic [SW-1:0]  sel_q,
    input  logic           gn,
    output logic [W-1:0]   out_data,
    output logic           out_valid,
    input  logic           out_ready
);

    logic [SW-1:0] sel_lat_q;
    logic [SW-1:0] sel_lat_d;
    logic [SW-1:0] eff;
    logic [W-1:0]  in_word;
    logic [W-1:0]  main_data;
    logic          main_vld;
    logic          ready_eff;
    mxn_xfer_t     xfer;

    // ---------------------------------------------------------------------
    // Select latch. A transfer in the loading cycle still uses the old
    // select because eff is derived from the registered value only.
    // ---------------------------------------------------------------------
    always_comb begin
        sel_lat_d = sel_ld ? sel : sel_lat_q;
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            sel_lat_q <= '0;
        end else begin
            sel_lat_q <= sel_lat_d;
        end
    end

    assign sel_q   = sel_lat_q;
    assign eff     = SW'(mxn_eff_sel(32'(sel_lat_q), N));
    assign in_word = in_data[eff*W +: W];

    // ---------------------------------------------------------------------
    // Handshakes. Output side is masked by resetl so nothing is consumed
    // in a reset cycle.
    // ---------------------------------------------------------------------
    always_comb begin
        xfer          = '0;
        xfer.out_fire = main_vld & out_ready & ~gn & resetl;
        xfer.in_fire  = in_valid[eff] & ready_eff;
    end

    always_comb begin
        in_ready      = '0;
        in_ready[eff] = ready_eff;
    end

    assign out_valid = main_vld & ~gn & resetl;
    assign out_data  = out_valid ? main_data : '0;

`ifdef MXN_PIPE_SKID_EN
    // ---------------------------------------------------------------------
    // Two-slot datapath. Main slot feeds the output; skid slot catches the
    // word accepted while main is full and stalled. Ready is registered as
    // the complement of the next skid occupancy, so there is no path from
    // out_ready/gn to in_ready. Its reset value keeps in_ready low in reset.
    // ---------------------------------------------------------------------
    logic [W-1:0] skid_data;
    logic         skid_vld;
    logic         main_ld;
    logic [W-1:0] main_d;
    logic         skid_ld;
    logic         ready_q;
    logic         ready_d;

    always_comb begin
        // Skid occupied: it is the older word and refills main on drain.
        // Skid empty: new word lands in main if main is free or draining.
        main_ld = skid_vld ? xfer.out_fire
                           : (xfer.in_fire & (~main_vld | xfer.out_fire));
        main_d  = skid_vld ? skid_data : in_word;
        skid_ld = xfer.in_fire & main_vld & ~xfer.out_fire;
        ready_d = ~(skid_ld | (skid_vld & ~xfer.out_fire));
    end

    always_ff @(posedge sys_clk) begin
        if (!resetl) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= ready_d;
        end
    end

    assign ready_eff = ready_q;

    mxn_slot #(.W(W)) u_main (
        .sys_clk_i (sys_clk),
        .resetl_i  (resetl),
        .ld_i      (main_ld),
        .clr_i     (xfer.out_fire),
        .d_i       (main_d),
        .q_o       (main_data),
        .vld_o     (main_vld)
    );

    mxn_slot #(.W(W)) u_skid (
        .sys_clk_i (sys_clk),
        .resetl_i  (resetl),
        .ld_i      (skid_ld),
        .clr_i     (xfer.out_fire),
        .d_i       (in_word),
        .q_o       (skid_data),
        .vld_o     (skid_vld)
    );
`else
    // ---------------------------------------------------------------------
    // Single-slot datapath. Accept when empty or when the stored word is
    // leaving this cycle, which lets a full slot refill without a bubble.
    // ---------------------------------------------------------------------
    assign ready_eff = resetl & (~main_vld | (out_ready & ~gn));

    mxn_slot #(.W(W)) u_main (
        .sys_clk_i (sys_clk),
        .resetl_i  (resetl),
        .ld_i      (xfer.in_fire),
        .clr_i     (xfer.out_fire),
        .d_i       (in_word),
        .q_o       (main_data),
        .vld_o     (main_vld)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_mxn_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mxn_pipe
//  Description : Directed self-checking bench for mxn_pipe. One instance with
//                N=8/W=8 runs a vector table plus hand-written gate,
//                backpressure, reset and select-change sequences; a second
//                instance with N=6/W=8 exercises the out-of-range select.
//  Build macro : MXN_PIPE_SKID_EN selects the skid-slot expectations.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_mxn_pipe;

`ifdef MXN_PIPE_SKID_EN
    localparam bit SKID = 1'b1;
`else
    localparam bit SKID = 1'b0;
`endif

    logic        clk;
    logic        resetl;

    // N=8, W=8 instance
    logic [63:0] in_data;
    logic [7:0]  in_valid;
    logic [7:0]  in_ready;
    logic [2:0]  sel;
    logic        sel_ld;
    logic [2:0]  sel_q;
    logic        gn;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready;

    // N=6, W=8 instance
    logic [47:0] in_data6;
    logic [5:0]  in_valid6;
    logic [5:0]  in_ready6;
    logic [2:0]  sel6;
    logic        sel_ld6;
    logic [2:0]  sel_q6;
    logic        gn6;
    logic [7:0]  out_data6;
    logic        out_valid6;
    logic        out_ready6;

    int n_checks = 0;
    int n_fail   = 0;

    mxn_pipe #(.N(8), .W(8)) u_dut (
        .sys_clk   (clk),
        .resetl    (resetl),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .sel       (sel),
        .sel_ld    (sel_ld),
        .sel_q     (sel_q),
        .gn        (gn),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    mxn_pipe #(.N(6), .W(8)) u_dut6 (
        .sys_clk   (clk),
        .resetl    (resetl),
        .in_data   (in_data6),
        .in_valid  (in_valid6),
        .in_ready  (in_ready6),
        .sel       (sel6),
        .sel_ld    (sel_ld6),
        .sel_q     (sel_q6),
        .gn        (gn6),
        .out_data  (out_data6),
        .out_valid (out_valid6),
        .out_ready (out_ready6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [2:0] sel;
        logic       ld;
        int         ch;        // 8 = no channel valid
        logic [7:0] data;
        logic       ordy;
        logic       g;
        logic [7:0] exp_rdy;   // in_ready before the edge
        logic       exp_vld;   // out_valid after the edge
        logic [7:0] exp_data;  // out_data after the edge
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ch(input int ch, input logic [7:0] d);
        in_valid = '0;
        in_data  = '0;
        if (ch < 8) begin
            in_valid[ch]       = 1'b1;
            in_data[ch*8 +: 8] = d;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] words [3];
        logic [7:0] got   [$];
        logic [7:0] w;
        int         idx;

        // sel, ld, ch, data, ordy, gn, exp_rdy, exp_vld, exp_data
        vecs[0] = '{3'd5, 1'b1, 0, 8'h5A, 1'b1, 1'b0, 8'h01, 1'b1, 8'h5A};
        vecs[1] = '{3'd0, 1'b0, 5, 8'hA5, 1'b1, 1'b0, 8'h20, 1'b1, 8'hA5};
        vecs[2] = '{3'd0, 1'b0, 3, 8'h33, 1'b1, 1'b0, 8'h20, 1'b0, 8'h00};
        vecs[3] = '{3'd7, 1'b1, 8, 8'h00, 1'b1, 1'b0, 8'h20, 1'b0, 8'h00};
        vecs[4] = '{3'd0, 1'b0, 7, 8'hC7, 1'b1, 1'b0, 8'h80, 1'b1, 8'hC7};
        vecs[5] = '{3'd0, 1'b0, 8, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 8'h00};
        vecs[6] = '{3'd2, 1'b1, 7, 8'h77, 1'b0, 1'b0, 8'h80, 1'b1, 8'h77};
        vecs[7] = '{3'd0, 1'b0, 2, 8'h22, 1'b1, 1'b0, 8'h04, 1'b1, 8'h22};
        vecs[8] = '{3'd0, 1'b0, 8, 8'h00, 1'b1, 1'b0, 8'h04, 1'b0, 8'h00};

        words[0] = 8'h01;
        words[1] = 8'h02;
        words[2] = 8'h03;

        // ---------------- reset with every channel valid ----------------
        resetl     = 1'b0;
        in_data    = {8{8'hFF}};
        in_valid   = 8'hFF;
        sel        = 3'd3;
        sel_ld     = 1'b1;
        gn         = 1'b0;
        out_ready  = 1'b1;
        in_data6   = {6{8'hFF}};
        in_valid6  = 6'h3F;
        sel6       = 3'd0;
        sel_ld6    = 1'b0;
        gn6        = 1'b0;
        out_ready6 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_out_data",  64'(out_data),  64'(0));
            check("rst_sel_q",     64'(sel_q),     64'(0));
            check("rst_in_ready",  64'(in_ready),  64'(0));
            check("rst_in_ready6", 64'(in_ready6), 64'(0));
        end
        resetl    = 1'b1;
        sel_ld    = 1'b0;
        sel       = 3'd0;
        set_ch(8, 8'h00);
        in_valid6 = '0;
        in_data6  = '0;
        step();

        // ---------------- vector table ----------------
        foreach (vecs[k]) begin
            sel       = vecs[k].sel;
            sel_ld    = vecs[k].ld;
            set_ch(vecs[k].ch, vecs[k].data);
            out_ready = vecs[k].ordy;
            gn        = vecs[k].g;
            #1;
            check($sformatf("vec%0d_in_ready", k), 64'(in_ready), 64'(vecs[k].exp_rdy));
            step();
            check($sformatf("vec%0d_out_valid", k), 64'(out_valid), 64'(vecs[k].exp_vld));
            check($sformatf("vec%0d_out_data", k),  64'(out_data),  64'(vecs[k].exp_data));
        end
        sel_ld = 1'b0;
        check("table_sel_q", 64'(sel_q), 64'(2));

        // ---------------- gate holds a stored word ----------------
        set_ch(2, 8'h3C);
        out_ready = 1'b1;
        gn        = 1'b0;
        step();
        set_ch(8, 8'h00);
        gn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("gate_out_valid", 64'(out_valid), 64'(0));
            check("gate_out_data",  64'(out_data),  64'(0));
            check("gate_in_ready",  64'(in_ready),  SKID ? 64'h04 : 64'h00);
            step();
        end
        gn = 1'b0;
        #1;
        check("ungate_out_valid", 64'(out_valid), 64'(1));
        check("ungate_out_data",  64'(out_data),  64'h3C);
        step();
        check("ungate_once", 64'(out_valid), 64'(0));

        // ---------------- backpressure stream 1,2,3 on ch2 ----------------
        out_ready = 1'b0;
        idx       = 0;
        for (int i = 0; i < 4; i++) begin
            w = (idx < 3) ? words[idx] : 8'h00;
            set_ch((idx < 3) ? 2 : 8, w);
            #1;
            if (in_valid[2] && in_ready[2]) idx++;
            step();
        end
        check("bp_accepted", 64'(idx), SKID ? 64'(2) : 64'(1));
        w = (idx < 3) ? words[idx] : 8'h00;
        set_ch(2, w);
        #1;
        check("bp_in_ready_low", 64'(in_ready[2]), 64'(0));
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            w = (idx < 3) ? words[idx] : 8'h00;
            set_ch((idx < 3) ? 2 : 8, w);
            #1;
            if (out_valid && out_ready) got.push_back(out_data);
            if (in_valid[2] && in_ready[2]) idx++;
            step();
        end
        check("bp_out_count", 64'(got.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            w = (i < got.size()) ? got[i] : 8'hXX;
            check($sformatf("bp_out_word%0d", i), 64'(w), 64'(words[i]));
        end

        // ---------------- reset discards a stored word ----------------
        set_ch(2, 8'h99);
        out_ready = 1'b0;
        step();
        set_ch(8, 8'h00);
        resetl = 1'b0;
        #1;
        check("midrst_out_valid_comb", 64'(out_valid), 64'(0));
        step();
        check("midrst_in_ready", 64'(in_ready), 64'(0));
        resetl    = 1'b1;
        out_ready = 1'b1;
        step();
        step();
        check("midrst_discarded", 64'(out_valid), 64'(0));

        // ---------------- out-of-range select on N=6 ----------------
        sel6    = 3'd7;
        sel_ld6 = 1'b1;
        step();
        sel_ld6 = 1'b0;
        #1;
        check("oor_sel_q",    64'(sel_q6),    64'(7));
        check("oor_in_ready", 64'(in_ready6), 64'h20);
        in_valid6          = 6'h20;
        in_data6[40 +: 8]  = 8'h5F;
        step();
        in_valid6 = '0;
        check("oor_out_valid", 64'(out_valid6), 64'(1));
        check("oor_out_data",  64'(out_data6),  64'h5F);

        // ---------------- select change during transfer ----------------
        sel    = 3'd1;
        sel_ld = 1'b1;
        set_ch(8, 8'h00);
        step();
        sel              = 3'd4;
        in_valid         = 8'b0001_0010;
        in_data          = '0;
        in_data[8 +: 8]  = 8'h11;
        in_data[32 +: 8] = 8'h44;
        step();
        sel_ld = 1'b0;
        check("selchg_sel_q",  64'(sel_q),    64'(4));
        check("selchg_first",  64'(out_data), 64'h11);
        step();
        in_valid = '0;
        check("selchg_second", 64'(out_data), 64'h44);
        step();
        check("selchg_drained", 64'(out_valid), 64'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
